bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Parametrised branch history table (BHT) of saturating counters, indexed by PC. Next generation of the single-counter branch predictor.
- Sits in the IF stage: combinational lookup for the fetched PC; the counter is trained from the EX stage when the branch resolves.
- Adds per-entry counters, configurable counter width, and a resolve-time update port.
- Adds running branch and mispredict statistics counters.

Parameters:
- ENTRIES, 64: number of table entries; power of 2, minimum 4. IDX_W = log2(ENTRIES).
- CNT_W, 2: saturating counter width; minimum 2.
- GHR_W, 6: global history length, used only with GSHARE_EN; 1 <= GHR_W <= IDX_W.
- BR_OPCODE, 7'b1100011: opcode that identifies a conditional branch.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pred_valid  in  1  fetch slot valid
- pred_opcode  in  7  opcode of the fetched instruction
- pred_pc  in  32  PC of the fetched instruction
- pred_branch  out  1  fetched instruction is a conditional branch
- pred_taken  out  1  predicted taken
- pred_cnt  out  CNT_W  counter value read for this lookup
- pred_idx  out  IDX_W  table index used; carried down the pipe to the update port
- pred_pc_out  out  32  pred_pc when pred_branch=1, else 0
- upd_valid  in  1  one branch resolved this cycle
- upd_idx  in  IDX_W  index returned from pred_idx of that branch
- upd_taken  in  1  actual branch outcome
- upd_mispredict  in  1  prediction was wrong
- stat_br  out  32  resolved-branch count
- stat_mis  out  32  mispredict count

Behaviour:
- Reset: rst is synchronous and active-high. Clock is clk.
- On reset, all ENTRIES counters load RST_CNT = 2^(CNT_W-1)-1 (weakly not-taken; 2'b01 for CNT_W=2).
- On reset, stat_br and stat_mis load 0, and the GHR (if present) loads 0.
- The table is held in flops so reset completes in one cycle.
- Lookup is purely combinational, zero latency:
  - Index base = pred_pc[IDX_W+1:2]. Bits [1:0] are ignored (word-aligned PC).
  - pred_branch = pred_valid & (pred_opcode == BR_OPCODE).
  - pred_cnt = table[pred_idx], driven regardless of pred_branch.
  - pred_taken = pred_branch & MSB of pred_cnt.
  - pred_pc_out = pred_branch ? pred_pc : 0.
- Update, on posedge clk when upd_valid=1 and rst=0:
  - upd_taken=1: table[upd_idx] increments, saturating at all-ones.
  - upd_taken=0: table[upd_idx] decrements, saturating at 0.
  - No wrap-around under any sequence.
- Counter states for CNT_W=2: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Each update moves the counter one step.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Only one update per cycle. upd_mispredict is ignored when upd_valid=0.
- Statistics:
  - stat_br increments on each valid update.
  - stat_mis increments on upd_valid & upd_mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- rst asserted in the same cycle as upd_valid: reset wins and the update is dropped.
- Lookup outputs during rst reflect the current pre-reset table contents. Callers ignore them.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - A GHR_W-bit global history register is instantiated.
  - pred_idx = base index XOR {zero-extend GHR}.
  - On each valid update, GHR <= {GHR[GHR_W-2:0], upd_taken}. For GHR_W=1, GHR <= upd_taken.
  - History is non-speculative (updated at resolve only). Lookup uses the pre-update GHR in the same cycle.
- Not defined:
  - No GHR flops.
  - pred_idx = pred_pc[IDX_W+1:2] exactly.

Test Plan:
- Reset, then lookup pc=0x40 with opcode 1100011, valid=1 -> pred_branch=1, pred_idx=16, pred_cnt=01, pred_taken=0, pred_pc_out=0x40, stat_br=stat_mis=0.
- Update idx 16 with taken=1 for 4 consecutive cycles -> pred_cnt goes 10, 11, 11, 11; pred_taken=1 from the cycle after the first update; no wrap to 00.
- Update idx 16 with taken=0 for 5 cycles -> counter goes 10, 01, 00, 00, 00; it holds at 00 (no underflow).
- Lookup idx 5 while updating idx 5 with taken=1, starting from 01 -> same-cycle pred_cnt=01; next cycle pred_cnt=10.
- Lookup with opcode 0110011 (ALU op) -> pred_branch=0, pred_taken=0, pred_pc_out=0. Lookup with pred_valid=0 and a branch opcode -> pred_branch=0.
- 3 updates with mispredict=1,0,1, then assert rst together with a 4th update -> stat_br=3, stat_mis=2 before reset; all zero after reset; the 4th update is not applied.
- With BHT_GSHARE_EN: after updates with taken=1,0,1, GHR=6'b000101; lookup pc=0x40 -> pred_idx=16^5=21.

Source files
------------

// File: rtl/bht_predictor.sv
// -----------------------------------------------------------------------------
// bht_predictor
//   Branch history table of saturating counters indexed by the fetch PC.
//   The lookup side is purely combinational and sits in the IF stage.
//   Counters are trained from the EX stage through the resolve-time update
//   port. Two 32-bit saturating statistics counters track resolved branches
//   and mispredicts.
//
// Optional feature macro: BHT_GSHARE_EN
//   When defined, a GHR_W-bit global history register is built. It is XORed
//   into the low bits of the table index and is shifted at resolve time only,
//   so the history is non-speculative.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   pred_valid      fetch slot valid
//   pred_opcode     opcode of the fetched instruction
//   pred_pc         PC of the fetched instruction
//   pred_branch     fetched instruction is a conditional branch
//   pred_taken      predicted taken
//   pred_cnt        counter value read for this lookup
//   pred_idx        table index used (carried down the pipe to upd_idx)
//   pred_pc_out     pred_pc when pred_branch=1, else 0
//   upd_valid       one branch resolved this cycle
//   upd_idx         index that branch was predicted with
//   upd_taken       actual branch outcome
//   upd_mispredict  prediction was wrong
//   stat_br         resolved-branch count (saturating)
//   stat_mis        mispredict count (saturating)
// -----------------------------------------------------------------------------
module bht_predictor #(
    parameter int         ENTRIES   = 64,
    parameter int         CNT_W     = 2,
    parameter int         GHR_W     = 6,
    parameter logic [6:0] BR_OPCODE = 7'b1100011
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pred_valid,
    input  logic [6:0]                  pred_opcode,
    input  logic [31:0]                 pred_pc,
    output logic                        pred_branch,
    output logic                        pred_taken,
    output logic [CNT_W-1:0]            pred_cnt,
    output logic [$clog2(ENTRIES)-1:0]  pred_idx,
    output logic [31:0]                 pred_pc_out,
    input  logic                        upd_valid,
    input  logic [$clog2(ENTRIES)-1:0]  upd_idx,
    input  logic                        upd_taken,
    input  logic                        upd_mispredict,
    output logic [31:0]                 stat_br,
    output logic [31:0]                 stat_mis
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] RST_CNT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      STAT_MAX = 32'hFFFF_FFFF;

    // One saturating step of a prediction counter toward taken or not-taken.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             up);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != CNT_MAX) begin
                res = cnt + CNT_ONE;
            end else begin
                res = cnt;
            end
        end else begin
            if (cnt != CNT_MIN) begin
                res = cnt - CNT_ONE;
            end else begin
                res = cnt;
            end
        end
        return res;
    endfunction

    // Saturating increment for the 32-bit statistics counters.
    function automatic logic [31:0] stat_inc(input logic [31:0] val);
        logic [31:0] res;
        if (val != STAT_MAX) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [CNT_W-1:0] table_r [ENTRIES];
    logic [IDX_W-1:0] base_idx_s;
    logic [CNT_W-1:0] upd_cnt_next_s;
    logic [31:0]      stat_br_r;
    logic [31:0]      stat_mis_r;

    // Word-aligned PC: bits [1:0] never contribute to the index.
    assign base_idx_s = pred_pc[IDX_W+1:2];

`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] ghr_r;
    logic [GHR_W-1:0] ghr_next_s;

    // Shift the resolved outcome into the history; a loop avoids an empty
    // slice when GHR_W is 1.
    always_comb begin
        ghr_next_s    = ghr_r;
        ghr_next_s[0] = upd_taken;
        for (int i = 1; i < GHR_W; i++) begin
            ghr_next_s[i] = ghr_r[i-1];
        end
    end

    // Global history register, advanced only when a branch resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= {GHR_W{1'b0}};
        end else if (upd_valid) begin
            ghr_r <= ghr_next_s;
        end
    end

    // Lookup uses the pre-update history of this cycle.
    assign pred_idx = base_idx_s ^ IDX_W'(ghr_r);
`else
    assign pred_idx = base_idx_s;
`endif

    // Combinational lookup; no bypass from a same-cycle update.
    always_comb begin
        pred_branch = pred_valid & (pred_opcode == BR_OPCODE);
        pred_cnt    = table_r[pred_idx];
        pred_taken  = pred_branch & pred_cnt[CNT_W-1];
        if (pred_branch) begin
            pred_pc_out = pred_pc;
        end else begin
            pred_pc_out = 32'h0000_0000;
        end
    end

    // Next value of the counter being trained this cycle.
    always_comb begin
        upd_cnt_next_s = cnt_step(table_r[upd_idx], upd_taken);
    end

    // Counter table in flops so the whole table resets in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= RST_CNT;
            end
        end else if (upd_valid) begin
            table_r[upd_idx] <= upd_cnt_next_s;
        end
    end

    // Resolved-branch and mispredict statistics; reset drops a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_r  <= 32'h0000_0000;
            stat_mis_r <= 32'h0000_0000;
        end else if (upd_valid) begin
            stat_br_r <= stat_inc(stat_br_r);
            if (upd_mispredict) begin
                stat_mis_r <= stat_inc(stat_mis_r);
            end
        end
    end

    assign stat_br  = stat_br_r;
    assign stat_mis = stat_mis_r;

endmodule

// File: tb/tb_bht_predictor.sv
// -----------------------------------------------------------------------------
// tb_bht_predictor
//   Directed, table-driven bench for bht_predictor (default parameters).
//   Inputs change on the falling edge; combinational outputs are sampled 2ns
//   later, before the rising edge that applies any update.
// -----------------------------------------------------------------------------
module tb_bht_predictor;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [6:0]  pred_opcode;
    logic [31:0] pred_pc;
    logic        pred_branch;
    logic        pred_taken;
    logic [1:0]  pred_cnt;
    logic [5:0]  pred_idx;
    logic [31:0] pred_pc_out;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] stat_br;
    logic [31:0] stat_mis;

    int n_checks;
    int n_fail;

    bht_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_opcode    (pred_opcode),
        .pred_pc        (pred_pc),
        .pred_branch    (pred_branch),
        .pred_taken     (pred_taken),
        .pred_cnt       (pred_cnt),
        .pred_idx       (pred_idx),
        .pred_pc_out    (pred_pc_out),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .stat_br        (stat_br),
        .stat_mis       (stat_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        um;
        logic        e_br;
        logic        e_tk;
        logic [1:0]  e_cnt;
        logic [5:0]  e_idx;
        logic [31:0] e_pco;
        logic [31:0] e_sbr;
        logic [31:0] e_smis;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [31:0] pc,
                         input logic uv, input logic [5:0] ui, input logic ut, input logic um);
        @(negedge clk);
        pred_valid     = v;
        pred_opcode    = op;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_idx        = ui;
        upd_taken      = ut;
        upd_mispredict = um;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        upd_valid = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
    endtask

    function automatic vec_t mkv(input logic v, input logic [6:0] op, input logic [31:0] pc,
                                 input logic uv, input logic [5:0] ui, input logic ut,
                                 input logic um, input logic e_br, input logic e_tk,
                                 input logic [1:0] e_cnt, input logic [5:0] e_idx,
                                 input logic [31:0] e_pco, input logic [31:0] e_sbr,
                                 input logic [31:0] e_smis);
        vec_t r;
        r.v = v; r.op = op; r.pc = pc; r.uv = uv; r.ui = ui; r.ut = ut; r.um = um;
        r.e_br = e_br; r.e_tk = e_tk; r.e_cnt = e_cnt; r.e_idx = e_idx;
        r.e_pco = e_pco; r.e_sbr = e_sbr; r.e_smis = e_smis;
        return r;
    endfunction

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        pred_valid     = 1'b0;
        pred_opcode    = 7'b0000000;
        pred_pc        = 32'h0000_0000;
        upd_valid      = 1'b0;
        upd_idx        = 6'd0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;

        // Expected values: each row shows the pre-update table state for its
        // own update, and stats count the updates of all earlier rows.
        vecs[0]  = mkv(1'b1, BR,  32'h40, 1'b0, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 6'd16, 32'h40, 32'd0,  32'd0);
        vecs[1]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 6'd16, 32'h40, 32'd0,  32'd0);
        vecs[2]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 6'd16, 32'h40, 32'd1,  32'd0);
        vecs[3]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 6'd16, 32'h40, 32'd2,  32'd1);
        vecs[4]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 6'd16, 32'h40, 32'd3,  32'd1);
        vecs[5]  = mkv(1'b1, BR,  32'h40, 1'b0, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 6'd16, 32'h40, 32'd4,  32'd1);
        vecs[6]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 6'd16, 32'h40, 32'd4,  32'd1);
        vecs[7]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 6'd16, 32'h40, 32'd5,  32'd1);
        vecs[8]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 6'd16, 32'h40, 32'd6,  32'd1);
        vecs[9]  = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd16, 32'h40, 32'd7,  32'd2);
        vecs[10] = mkv(1'b1, BR,  32'h40, 1'b1, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd16, 32'h40, 32'd8,  32'd2);
        vecs[11] = mkv(1'b1, BR,  32'h40, 1'b0, 6'd16, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 6'd16, 32'h40, 32'd9,  32'd2);
        vecs[12] = mkv(1'b1, BR,  32'h14, 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 6'd5,  32'h14, 32'd9,  32'd2);
        vecs[13] = mkv(1'b1, BR,  32'h14, 1'b0, 6'd5,  1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 6'd5,  32'h14, 32'd10, 32'd2);
        vecs[14] = mkv(1'b1, ALU, 32'h14, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 6'd5,  32'h0,  32'd10, 32'd2);
        vecs[15] = mkv(1'b0, BR,  32'h14, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 6'd5,  32'h0,  32'd10, 32'd2);
        vecs[16] = mkv(1'b1, BR,  32'h1234_56FC, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 6'd63, 32'h1234_56FC, 32'd10, 32'd2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of every entry and the statistics.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, BR, 32'(i) << 2, 1'b0, 6'd0, 1'b0, 1'b0);
            chk($sformatf("rst_cnt[%0d]", i), 32'(pred_cnt), 32'h1);
            chk($sformatf("rst_idx[%0d]", i), 32'(pred_idx), 32'(i));
        end
        chk("rst_stat_br", stat_br, 32'd0);
        chk("rst_stat_mis", stat_mis, 32'd0);

`ifndef BHT_GSHARE_EN
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].v, vecs[k].op, vecs[k].pc, vecs[k].uv, vecs[k].ui, vecs[k].ut, vecs[k].um);
            chk($sformatf("v%0d_branch", k), 32'(pred_branch), 32'(vecs[k].e_br));
            chk($sformatf("v%0d_taken", k),  32'(pred_taken),  32'(vecs[k].e_tk));
            chk($sformatf("v%0d_cnt", k),    32'(pred_cnt),    32'(vecs[k].e_cnt));
            chk($sformatf("v%0d_idx", k),    32'(pred_idx),    32'(vecs[k].e_idx));
            chk($sformatf("v%0d_pc_out", k), pred_pc_out,      vecs[k].e_pco);
            chk($sformatf("v%0d_stat_br", k),  stat_br,        vecs[k].e_sbr);
            chk($sformatf("v%0d_stat_mis", k), stat_mis,       vecs[k].e_smis);
        end
`endif

        // Statistics, then reset colliding with a fourth update.
        do_reset();
        drive(1'b0, BR, 32'h0, 1'b1, 6'd7, 1'b1, 1'b1);
        drive(1'b0, BR, 32'h0, 1'b1, 6'd7, 1'b1, 1'b0);
        drive(1'b0, BR, 32'h0, 1'b1, 6'd7, 1'b1, 1'b1);
        drive(1'b1, BR, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("seq_stat_br", stat_br, 32'd3);
        chk("seq_stat_mis", stat_mis, 32'd2);
`ifndef BHT_GSHARE_EN
        chk("seq_cnt7", 32'(pred_cnt), 32'h3);
`endif
        @(negedge clk);
        rst            = 1'b1;
        upd_valid      = 1'b1;
        upd_idx        = 6'd9;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        upd_valid = 1'b0;
        pred_pc   = 32'h24;
        #2;
        chk("rstupd_cnt9", 32'(pred_cnt), 32'h1);
        chk("rstupd_idx9", 32'(pred_idx), 32'd9);
        chk("rstupd_stat_br", stat_br, 32'd0);
        chk("rstupd_stat_mis", stat_mis, 32'd0);
        drive(1'b1, BR, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("rstupd_cnt7", 32'(pred_cnt), 32'h1);

`ifdef BHT_GSHARE_EN
        // History 1,0,1 -> 6'b000101; lookup sees the pre-update history.
        drive(1'b1, BR, 32'h40, 1'b1, 6'd0, 1'b1, 1'b0);
        chk("gs_idx_h0", 32'(pred_idx), 32'd16);
        drive(1'b1, BR, 32'h40, 1'b1, 6'd0, 1'b0, 1'b0);
        chk("gs_idx_h1", 32'(pred_idx), 32'd17);
        drive(1'b1, BR, 32'h40, 1'b1, 6'd0, 1'b1, 1'b0);
        chk("gs_idx_h2", 32'(pred_idx), 32'd18);
        drive(1'b1, BR, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("gs_idx_h5", 32'(pred_idx), 32'd21);
        do_reset();
        drive(1'b1, BR, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("gs_idx_rst", 32'(pred_idx), 32'd16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
